load_unit: RTL

- Load-side counterpart to the store-side byte/halfword packer in the data-memory path.
- Takes a load request (lw/lh/lb, signed or unsigned), issues a word-aligned read to data memory over a req/ready handshake, and extracts the addressed byte/halfword.
- Sign- or zero-extends the extracted value and presents a registered 32-bit result with a one-cycle done pulse.
- Sits between the execute stage and the data-memory read port.

---
 rtl/load_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// Load unit: issues word-aligned memory reads and extracts a sign/zero-extended byte, halfword or word.
// Define LOAD_UNIT_SPLIT_EN to split word-crossing loads into two reads; otherwise they are flagged misaligned.
module load_unit #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              lb,
   input  logic              lh,
   input  logic              lu,
   input  logic [ADDR_W-1:0] addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       data_out,
   output logic              misaligned
);

   typedef enum logic [1:0] {IDLE, REQ, REQ2, DONE} state_t;

   state_t      state;
   logic [1:0]  off_q;
   logic        lb_q;
   logic        lh_q;
   logic        lu_q;
   logic        split_c;
   logic [63:0] rd_c;
`ifdef LOAD_UNIT_SPLIT_EN
   logic [31:0] w0;
`endif

   // Access crosses a word boundary: halfword at offset 3, or word at nonzero offset.
   function automatic logic is_mis(input logic [1:0] off, input logic b, input logic h);
      return (!b && h && off == 2'd3) || (b == h && off != 2'd0);
   endfunction

   function automatic logic [31:0] extract(input logic [63:0] v, input logic [1:0] off,
                                           input logic b, input logic h, input logic u);
      logic [31:0] r;
      r = 32'(v >> {off, 3'b000});
      if (!b && h)      return u ? {16'h0, r[15:0]} : {{16{r[15]}}, r[15:0]};
      else if (b && !h) return u ? {24'h0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
      else              return r;
   endfunction

   always_comb begin
      split_c = 1'b0;
      rd_c    = {32'h0, mem_rdata};
`ifdef LOAD_UNIT_SPLIT_EN
      split_c = (state == REQ) && is_mis(off_q, lb_q, lh_q);
      if (state == REQ2) rd_c = {mem_rdata, w0};
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         off_q      <= 2'd0;
         lb_q       <= 1'b0;
         lh_q       <= 1'b0;
         lu_q       <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         data_out   <= 32'h0;
         misaligned <= 1'b0;
`ifdef LOAD_UNIT_SPLIT_EN
         w0         <= 32'h0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  off_q    <= addr[1:0];
                  lb_q     <= lb;
                  lh_q     <= lh;
                  lu_q     <= lu;
                  mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                  busy     <= 1'b1;
`ifdef LOAD_UNIT_SPLIT_EN
                  state    <= REQ;
                  mem_req  <= 1'b1;
`else
                  if (is_mis(addr[1:0], lb, lh)) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     data_out   <= 32'h0;
                     misaligned <= 1'b1;
                  end else begin
                     state   <= REQ;
                     mem_req <= 1'b1;
                  end
`endif
               end
            end
`ifdef LOAD_UNIT_SPLIT_EN
            REQ, REQ2: begin
`else
            REQ: begin
`endif
               if (mem_ready) begin
                  if (split_c) begin
`ifdef LOAD_UNIT_SPLIT_EN
                     w0 <= mem_rdata;
`endif
                     mem_addr <= mem_addr + ADDR_W'(4);
                     state    <= REQ2;
                  end else begin
                     state      <= DONE;
                     mem_req    <= 1'b0;
                     done       <= 1'b1;
                     data_out   <= extract(rd_c, off_q, lb_q, lh_q, lu_q);
                     misaligned <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
